jstk_cursor: RTL and testbench

- Sits directly downstream of the JSTK2 joystick interface. Consumes the raw 10-bit X/Y samples and button bits.
- Converts them into a held direction, single-cycle move/select events, and a saturating grid cursor position.
- Outputs drive the screen state machine, the VGA address generator and the LEDs. They replace the ad-hoc combinational threshold compares at top level.
- Adds hysteresis, dominant-axis arbitration and hold-to-repeat stepping.

---
 rtl/jstk_cursor.sv | 218 +++++++++++++++++++++
 tb/tb_jstk_cursor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_cursor.sv
// Turns raw joystick samples into a held direction, move/select pulses and a saturating grid cursor.
// Latency: a sample taken at edge n updates the classifiers at n+1, and dir/cursor/move_pulse at n+2. Buttons act at n+1.
// Backpressure: none. Every sample qualified by jstk_valid is consumed, and outputs are never stalled.
module jstk_cursor #(
  parameter int CENTER       = 512,
  parameter int DEAD         = 200,
  parameter int HYST         = 40,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int GRID_W       = 20,
  parameter int GRID_H       = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] jstk_x,
  input  logic [9:0] jstk_y,
  input  logic       jstk_valid,
  input  logic       btn_trigger,
  input  logic       btn_jstk,
  output logic [3:0] dir,
  output logic       move_pulse,
  output logic       select_pulse,
  output logic [4:0] cur_x,
  output logic [3:0] cur_y
);

  typedef enum logic [1:0] {AX_CENTER, AX_POS, AX_NEG} axis_e;
  typedef enum logic [1:0] {IDLE, STEP, DELAY, REPEAT} state_e;

  localparam int POS_ON  = CENTER + DEAD;
  localparam int NEG_ON  = CENTER - DEAD;
  localparam int POS_OFF = CENTER + DEAD - HYST;
  localparam int NEG_OFF = CENTER - DEAD + HYST;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [4:0] X_MID = 5'(GRID_W / 2);
  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [3:0] Y_MID = 4'(GRID_H / 2);
  localparam logic [3:0] Y_MAX = 4'(GRID_H - 1);
  localparam logic [3:0] DIR_UP = 4'b1000;
  localparam logic [3:0] DIR_DN = 4'b0100;
  localparam logic [3:0] DIR_LT = 4'b0010;
  localparam logic [3:0] DIR_RT = 4'b0001;

  // Thresholds are compared as plain integers, so values near 0 or 1023 cannot wrap.
  function automatic axis_e classify(input axis_e st, input logic [9:0] s);
    int    v;
    axis_e nxt;
    v   = int'(s);
    nxt = st;
    case (st)
      AX_CENTER: if (v > POS_ON) nxt = AX_POS; else if (v < NEG_ON) nxt = AX_NEG;
      AX_POS:    if (v < NEG_ON) nxt = AX_NEG; else if (v < POS_OFF) nxt = AX_CENTER;
      AX_NEG:    if (v > POS_ON) nxt = AX_POS; else if (v > NEG_OFF) nxt = AX_CENTER;
      default:   nxt = AX_CENTER;
    endcase
    return nxt;
  endfunction

  function automatic logic [10:0] magnitude(input logic [9:0] s);
    int v;
    v = int'(s);
    return (v >= CENTER) ? 11'(v - CENTER) : 11'(CENTER - v);
  endfunction

  logic             smp_vld_q, smp_vld_d;
  logic [9:0]       smp_x_q, smp_x_d, smp_y_q, smp_y_d;
  logic             smp_trig_q, smp_trig_d, smp_jb_q, smp_jb_d;
  axis_e            cls_x_q, cls_x_d, cls_y_q, cls_y_d;
  logic [10:0]      mag_x_q, mag_x_d, mag_y_q, mag_y_d;
  logic             trig_prev_q, trig_prev_d, jb_prev_q, jb_prev_d;
  logic             select_q, select_d;
  logic [3:0]       dir_q, dir_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cur_x_q, cur_x_d;
  logic [3:0]       cur_y_q, cur_y_d;
  logic             move_q, move_d;
  logic             recentre, step;
  logic [3:0]       x_dir, y_dir;

  // Stage 1: capture the qualified sample and button levels.
  always_comb begin
    smp_vld_d  = jstk_valid;
    smp_x_d    = jstk_valid ? jstk_x      : smp_x_q;
    smp_y_d    = jstk_valid ? jstk_y      : smp_y_q;
    smp_trig_d = jstk_valid ? btn_trigger : smp_trig_q;
    smp_jb_d   = jstk_valid ? btn_jstk    : smp_jb_q;
  end

  // Stage 2: classifiers, magnitudes from the same sample, and button edge detection.
  always_comb begin
    cls_x_d     = smp_vld_q ? classify(cls_x_q, smp_x_q) : cls_x_q;
    cls_y_d     = smp_vld_q ? classify(cls_y_q, smp_y_q) : cls_y_q;
    mag_x_d     = smp_vld_q ? magnitude(smp_x_q) : mag_x_q;
    mag_y_d     = smp_vld_q ? magnitude(smp_y_q) : mag_y_q;
    trig_prev_d = smp_vld_q ? smp_trig_q : trig_prev_q;
    jb_prev_d   = smp_vld_q ? smp_jb_q : jb_prev_q;
    select_d    = smp_vld_q & smp_trig_q & ~trig_prev_q;
    recentre    = smp_vld_q & smp_jb_q & ~jb_prev_q;
  end

  // Dominant axis: the larger deflection wins, and Y wins ties.
  always_comb begin
    x_dir = (cls_x_q == AX_POS) ? DIR_RT : (cls_x_q == AX_NEG) ? DIR_LT : 4'd0;
    y_dir = (cls_y_q == AX_POS) ? DIR_UP : (cls_y_q == AX_NEG) ? DIR_DN : 4'd0;
    if (y_dir != 4'd0 && (x_dir == 4'd0 || mag_y_q >= mag_x_q)) dir_d = y_dir;
    else dir_d = x_dir;
  end

  // Repeat FSM. A new direction steps immediately; held directions step on counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    if (dir_d == 4'd0) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (dir_d != dir_q) begin
      step    = 1'b1;
      state_d = STEP;
      cnt_d   = DELAY_LOAD;
    end else begin
      case (state_q)
        STEP, DELAY: begin
          if (cnt_q == '0) begin
            step    = 1'b1;
            state_d = REPEAT;
            cnt_d   = RATE_LOAD;
          end else begin
            state_d = DELAY;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        REPEAT: begin
          if (cnt_q == '0) begin
            step  = 1'b1;
            cnt_d = RATE_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Cursor update. Recentre overrides a step, moves saturate, and move_pulse flags a real change.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (recentre) begin
      cur_x_d = X_MID;
      cur_y_d = Y_MID;
    end else if (step) begin
      case (dir_d)
        DIR_UP:  if (cur_y_q != 4'd0)  cur_y_d = cur_y_q - 4'd1;
        DIR_DN:  if (cur_y_q != Y_MAX) cur_y_d = cur_y_q + 4'd1;
        DIR_LT:  if (cur_x_q != 5'd0)  cur_x_d = cur_x_q - 5'd1;
        DIR_RT:  if (cur_x_q != X_MAX) cur_x_d = cur_x_q + 5'd1;
        default: ;
      endcase
    end
    move_d = (cur_x_d != cur_x_q) || (cur_y_d != cur_y_q);
  end

  // State registers. Reset abandons any repeat in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_vld_q   <= 1'b0;
      smp_x_q     <= '0;
      smp_y_q     <= '0;
      smp_trig_q  <= 1'b0;
      smp_jb_q    <= 1'b0;
      cls_x_q     <= AX_CENTER;
      cls_y_q     <= AX_CENTER;
      mag_x_q     <= '0;
      mag_y_q     <= '0;
      trig_prev_q <= 1'b0;
      jb_prev_q   <= 1'b0;
      select_q    <= 1'b0;
      dir_q       <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_x_q     <= X_MID;
      cur_y_q     <= Y_MID;
      move_q      <= 1'b0;
    end else begin
      smp_vld_q   <= smp_vld_d;
      smp_x_q     <= smp_x_d;
      smp_y_q     <= smp_y_d;
      smp_trig_q  <= smp_trig_d;
      smp_jb_q    <= smp_jb_d;
      cls_x_q     <= cls_x_d;
      cls_y_q     <= cls_y_d;
      mag_x_q     <= mag_x_d;
      mag_y_q     <= mag_y_d;
      trig_prev_q <= trig_prev_d;
      jb_prev_q   <= jb_prev_d;
      select_q    <= select_d;
      dir_q       <= dir_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      move_q      <= move_d;
    end
  end

  assign dir          = dir_q;
  assign move_pulse   = move_q;
  assign select_pulse = select_q;
  assign cur_x        = cur_x_q;
  assign cur_y        = cur_y_q;

endmodule

// File: tb/tb_jstk_cursor.sv
// Bench for jstk_cursor with short repeat timing.
// A sample-level reference model predicts every output on every cycle.
// Directed scenarios add fixed expectations on timing, saturation and button behaviour.
module tb_jstk_cursor;

  localparam int C  = 512;
  localparam int DZ = 200;
  localparam int HY = 40;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] jstk_x = 10'd512;
  logic [9:0] jstk_y = 10'd512;
  logic       jstk_valid = 1'b0;
  logic       btn_trigger = 1'b0;
  logic       btn_jstk = 1'b0;
  logic [3:0] dir;
  logic       move_pulse, select_pulse;
  logic [4:0] cur_x;
  logic [3:0] cur_y;

  int errors = 0;
  int checks = 0;

  jstk_cursor #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .jstk_x(jstk_x), .jstk_y(jstk_y), .jstk_valid(jstk_valid),
    .btn_trigger(btn_trigger), .btn_jstk(btn_jstk), .dir(dir), .move_pulse(move_pulse),
    .select_pulse(select_pulse), .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  // Reference model. Axis state is -1/0/+1. Repeat steps come from the time elapsed since the direction began.
  int m_k, t_start, mcx, mcy, mmx, mmy, px, py, m_cx, m_cy;
  bit pv, ptr, pjb, prev_tr, prev_jb, m_move, m_sel;
  logic [3:0] m_dir;

  function automatic int m_classify(input int st, input int v);
    if (st == 0) return (v > C + DZ) ? 1 : ((v < C - DZ) ? -1 : 0);
    if (st == 1) return (v < C - DZ) ? -1 : ((v < C + DZ - HY) ? 0 : 1);
    return (v > C + DZ) ? 1 : ((v > C - DZ + HY) ? 0 : -1);
  endfunction

  function automatic int m_absdev(input int v);
    return (v >= C) ? v - C : C - v;
  endfunction

  function automatic logic [3:0] m_dom(input int cx, input int cy, input int ax, input int ay);
    if (cy != 0 && (cx == 0 || ay >= ax)) return (cy > 0) ? 4'b1000 : 4'b0100;
    if (cx != 0) return (cx > 0) ? 4'b0001 : 4'b0010;
    return 4'b0000;
  endfunction

  function automatic logic [14:0] model_vec();
    return {m_dir, 5'(m_cx), 4'(m_cy), m_move, m_sel};
  endfunction

  task automatic model_reset();
    m_k = 0; t_start = 0; mcx = 0; mcy = 0; mmx = 0; mmy = 0; px = C; py = C;
    pv = 0; ptr = 0; pjb = 0; prev_tr = 0; prev_jb = 0;
    m_dir = 4'd0; m_cx = 10; m_cy = 7; m_move = 0; m_sel = 0;
  endtask

  task automatic model_step();
    logic [3:0] nd;
    bit stp, rec;
    int nx, ny, el;
    nd  = m_dom(mcx, mcy, mmx, mmy);
    stp = 0;
    if (nd != 4'd0) begin
      if (nd != m_dir) begin
        t_start = m_k;
        stp = 1;
      end else begin
        el  = m_k - t_start;
        stp = (el == RD) || (el > RD && ((el - RD) % RR) == 0);
      end
    end
    rec   = pv && pjb && !prev_jb;
    m_sel = pv && ptr && !prev_tr;
    nx = m_cx;
    ny = m_cy;
    if (rec) begin
      nx = 10; ny = 7;
    end else if (stp) begin
      if (nd == 4'b1000)      ny = (ny > 0)  ? ny - 1 : 0;
      else if (nd == 4'b0100) ny = (ny < 14) ? ny + 1 : 14;
      else if (nd == 4'b0010) nx = (nx > 0)  ? nx - 1 : 0;
      else                    nx = (nx < 19) ? nx + 1 : 19;
    end
    m_move = (nx != m_cx) || (ny != m_cy);
    m_cx = nx; m_cy = ny; m_dir = nd;
    if (pv) begin
      mcx = m_classify(mcx, px); mcy = m_classify(mcy, py);
      mmx = m_absdev(px);        mmy = m_absdev(py);
      prev_tr = ptr;             prev_jb = pjb;
    end
    pv = jstk_valid;
    if (jstk_valid) begin
      px = int'(jstk_x); py = int'(jstk_y); ptr = btn_trigger; pjb = btn_jstk;
    end
    m_k++;
  endtask

  // Advance one clock. The model updates at the edge and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step(); else model_reset();
    #1;
  endtask

  task automatic set_in(input int x, input int y, input bit v);
    jstk_x = 10'(x); jstk_y = 10'(y); jstk_valid = v;
  endtask

  task automatic test_reset();
    set_in(C, C, 0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (dir !== 4'd0)        begin errors++; $display("FAIL reset_dir: got %b expected 0000", dir); end
    checks++; if (cur_x !== 5'd10)     begin errors++; $display("FAIL reset_cur_x: got %0d expected 10", cur_x); end
    checks++; if (cur_y !== 4'd7)      begin errors++; $display("FAIL reset_cur_y: got %0d expected 7", cur_y); end
    checks++; if (move_pulse !== 1'b0) begin errors++; $display("FAIL reset_move: got %b expected 0", move_pulse); end
    checks++; if (select_pulse !== 1'b0) begin errors++; $display("FAIL reset_select: got %b expected 0", select_pulse); end
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic test_idle();
    int pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      set_in(C, C, (i % 10) == 0);
      tick();
      if (move_pulse || select_pulse) pulses++;
      checks++;
      if ({dir, cur_x, cur_y, move_pulse, select_pulse} !== model_vec()) begin
        errors++; $display("FAIL idle_cycle%0d: got %h expected %h", i, {dir, cur_x, cur_y, move_pulse, select_pulse}, model_vec());
      end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
    checks++; if ({cur_x, cur_y, dir} !== {5'd10, 4'd7, 4'd0}) begin
      errors++; $display("FAIL idle_state: got x=%0d y=%0d dir=%b expected x=10 y=7 dir=0000", cur_x, cur_y, dir);
    end
  endtask

  task automatic test_repeat();
    int first = -1, second = -1, last = -1, npulse = 0, fx = -1;
    set_in(800, C, 1);
    for (int e = 1; e <= 120; e++) begin
      tick();
      checks++;
      if ({dir, cur_x, cur_y, move_pulse, select_pulse} !== model_vec()) begin
        errors++; $display("FAIL repeat_cycle%0d: got %h expected %h", e, {dir, cur_x, cur_y, move_pulse, select_pulse}, model_vec());
      end
      if (move_pulse) begin
        npulse++;
        if (first < 0) begin first = e; fx = int'(cur_x); end
        else if (second < 0) second = e;
        last = e;
      end
    end
    checks++; if (first != 3)   begin errors++; $display("FAIL repeat_first_edge: got %0d expected 3", first); end
    checks++; if (fx != 11)     begin errors++; $display("FAIL repeat_first_x: got %0d expected 11", fx); end
    checks++; if (second != 23) begin errors++; $display("FAIL repeat_delay_edge: got %0d expected 23", second); end
    checks++; if (last != 79)   begin errors++; $display("FAIL repeat_last_edge: got %0d expected 79", last); end
    checks++; if (npulse != 9)  begin errors++; $display("FAIL repeat_count: got %0d expected 9", npulse); end
    checks++; if (cur_x !== 5'd19) begin errors++; $display("FAIL repeat_sat_x: got %0d expected 19", cur_x); end
    checks++; if (dir !== 4'b0001) begin errors++; $display("FAIL repeat_dir: got %b expected 0001", dir); end
  endtask

  task automatic test_hysteresis();
    int bad = 0;
    set_in(690, C, 1);
    repeat (10) tick();
    checks++; if (dir !== 4'b0001) begin errors++; $display("FAIL hyst_hold: got %b expected 0001", dir); end
    set_in(660, C, 1);
    tick(); tick();
    checks++; if (dir !== 4'b0001) begin errors++; $display("FAIL hyst_latency: got %b expected 0001", dir); end
    tick();
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL hyst_release: got %b expected 0000", dir); end
    set_in(700, C, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dir !== 4'b0000) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hyst_no_reentry: got %0d cycles with dir set expected 0", bad); end
    checks++;
    if ({dir, cur_x, cur_y, move_pulse, select_pulse} !== model_vec()) begin
      errors++; $display("FAIL hyst_model: got %h expected %h", {dir, cur_x, cur_y, move_pulse, select_pulse}, model_vec());
    end
  endtask

  task automatic test_diagonal();
    logic [3:0] y0;
    set_in(900, 850, 1);
    repeat (3) tick();
    checks++; if (dir !== 4'b0001) begin errors++; $display("FAIL diag_dominant: got %b expected 0001", dir); end
    y0 = cur_y;
    set_in(812, 812, 1);
    repeat (3) tick();
    checks++; if (dir !== 4'b1000) begin errors++; $display("FAIL diag_tie_dir: got %b expected 1000", dir); end
    checks++; if (cur_y !== y0 - 4'd1 || move_pulse !== 1'b1) begin
      errors++; $display("FAIL diag_tie_step: got y=%0d move=%b expected y=%0d move=1", cur_y, move_pulse, y0 - 4'd1);
    end
  endtask

  task automatic test_buttons();
    int sel = 0, extra = 0;
    set_in(C, C, 1);
    repeat (5) tick();
    btn_trigger = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (select_pulse) sel++;
      checks++;
      if ({dir, cur_x, cur_y, move_pulse, select_pulse} !== model_vec()) begin
        errors++; $display("FAIL trig_cycle%0d: got %h expected %h", i, {dir, cur_x, cur_y, move_pulse, select_pulse}, model_vec());
      end
    end
    checks++; if (sel != 1) begin errors++; $display("FAIL trig_single: got %0d pulses expected 1", sel); end
    btn_trigger = 1'b0;
    set_in(900, C, 1);
    repeat (80) tick();
    set_in(C, 900, 1);
    repeat (80) tick();
    set_in(C, C, 1);
    repeat (5) tick();
    checks++; if ({cur_x, cur_y} !== {5'd19, 4'd0}) begin
      errors++; $display("FAIL corner: got x=%0d y=%0d expected x=19 y=0", cur_x, cur_y);
    end
    btn_jstk = 1'b1;
    tick();
    checks++; if ({cur_x, cur_y} !== {5'd19, 4'd0}) begin
      errors++; $display("FAIL recentre_early: got x=%0d y=%0d expected x=19 y=0", cur_x, cur_y);
    end
    tick();
    checks++; if ({cur_x, cur_y, move_pulse} !== {5'd10, 4'd7, 1'b1}) begin
      errors++; $display("FAIL recentre: got x=%0d y=%0d move=%b expected x=10 y=7 move=1", cur_x, cur_y, move_pulse);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (move_pulse) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL recentre_hold: got %0d moves expected 0", extra); end
    btn_jstk = 1'b0;
  endtask

  task automatic test_random();
    int x = C, y = C;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: x = $urandom_range(0, 1023);
          1: x = $urandom_range(452, 572);
          2: x = $urandom_range(650, 900);
          default: x = $urandom_range(100, 370);
        endcase
        case ($urandom_range(0, 3))
          0: y = $urandom_range(0, 1023);
          1: y = $urandom_range(452, 572);
          2: y = $urandom_range(650, 900);
          default: y = $urandom_range(100, 370);
        endcase
      end
      if ($urandom_range(0, 19) == 0) btn_trigger = ~btn_trigger;
      if ($urandom_range(0, 29) == 0) btn_jstk = ~btn_jstk;
      set_in(x, y, $urandom_range(0, 9) < 7);
      tick();
      checks++;
      if ({dir, cur_x, cur_y, move_pulse, select_pulse} !== model_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, {dir, cur_x, cur_y, move_pulse, select_pulse}, model_vec());
      end
    end
    btn_trigger = 1'b0;
    btn_jstk = 1'b0;
  endtask

  task automatic test_reset_mid_repeat();
    int pulses = 0;
    set_in(C, C, 1);
    repeat (5) tick();
    set_in(100, C, 1);
    repeat (40) tick();
    #2 rst = 1'b0;
    model_reset();
    set_in(C, C, 1);
    #1;
    checks++; if ({dir, cur_x, cur_y, move_pulse, select_pulse} !== {4'd0, 5'd10, 4'd7, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midreset_outputs: got %h expected %h", {dir, cur_x, cur_y, move_pulse, select_pulse}, {4'd0, 5'd10, 4'd7, 1'b0, 1'b0});
    end
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (move_pulse || select_pulse) pulses++;
      checks++;
      if ({dir, cur_x, cur_y, move_pulse, select_pulse} !== model_vec()) begin
        errors++; $display("FAIL postreset_cycle%0d: got %h expected %h", i, {dir, cur_x, cur_y, move_pulse, select_pulse}, model_vec());
      end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL postreset_pulses: got %0d expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_repeat();
    test_hysteresis();
    test_diagonal();
    test_buttons();
    test_random();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
